alu_rs_scheduler: RTL and testbench

Reservation station and issue scheduler for the integer ALU. It buffers decoded ALU/branch operations from dispatch and captures missing source operands from the two result broadcast buses. Each cycle it selects one entry whose operands are all present and drives it into the combinational ALU as a registered operation. It sits between the dispatcher and the ALU, with the ROB tag carried through.

---
 rtl/alu_rs_scheduler_pkg.sv | 48 ++++
 rtl/alu_rs_scheduler_prio_enc.sv | 23 ++
 rtl/alu_rs_scheduler.sv | 155 +++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared constants, opcode encoding and operand types for the ALU reservation station.
// The capture helper is the single place that decides how a waiting operand picks up a broadcast.
package alu_rs_scheduler_pkg;

    localparam int RS_SIZE             = 16;
    localparam int RS_IDX_W            = 4;
    localparam int INSIDE_OPCODE_WIDTH = 6;
    localparam int ROB_TAG_WIDTH       = 5;
    localparam int DATA_WIDTH          = 32;

    localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;

    typedef enum logic [INSIDE_OPCODE_WIDTH-1:0] {
        NOP  = 6'd0,
        ADD  = 6'd1,
        SUB  = 6'd2,
        ADDI = 6'd3,
        SLT  = 6'd4,
        BEQ  = 6'd5,
        JAL  = 6'd6
    } inside_op_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    value;
        logic [ROB_TAG_WIDTH-1:0] tag;
    } operand_t;

    // A pending operand takes the ALU bus first, then the LSB bus; present operands pass through.
    function automatic operand_t capture(
        input operand_t                 src,
        input logic [ROB_TAG_WIDTH-1:0] alu_tag,
        input logic [DATA_WIDTH-1:0]    alu_value,
        input logic [ROB_TAG_WIDTH-1:0] lsb_tag,
        input logic [DATA_WIDTH-1:0]    lsb_value
    );
        operand_t res;
        res = src;
        if (src.tag != ZERO_TAG_ROB) begin
            if (src.tag == alu_tag) begin
                res = '{value: alu_value, tag: ZERO_TAG_ROB};
            end else if (src.tag == lsb_tag) begin
                res = '{value: lsb_value, tag: ZERO_TAG_ROB};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_scheduler_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest request and whether any was set.
module rs_prio_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scanning downward lets the lowest set bit be the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers dispatched ops, wakes operands from both result buses,
// and issues the lowest-index ready entry onto registered ALU operand outputs each cycle.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int RS_SIZE  = alu_rs_scheduler_pkg::RS_SIZE,
    parameter int RS_IDX_W = alu_rs_scheduler_pkg::RS_IDX_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [INSIDE_OPCODE_WIDTH-1:0] in_op,
    input  logic [DATA_WIDTH-1:0]          in_value1,
    input  logic [DATA_WIDTH-1:0]          in_value2,
    input  logic [ROB_TAG_WIDTH-1:0]       in_tag1,
    input  logic [ROB_TAG_WIDTH-1:0]       in_tag2,
    input  logic [DATA_WIDTH-1:0]          in_imm,
    input  logic [DATA_WIDTH-1:0]          in_pc,
    input  logic [ROB_TAG_WIDTH-1:0]       in_rob_tag,
    output logic                           out_full,
    input  logic [ROB_TAG_WIDTH-1:0]       cdb_alu_tag,
    input  logic [DATA_WIDTH-1:0]          cdb_alu_value,
    input  logic [ROB_TAG_WIDTH-1:0]       cdb_lsb_tag,
    input  logic [DATA_WIDTH-1:0]          cdb_lsb_value,
    output logic [INSIDE_OPCODE_WIDTH-1:0] out_op,
    output logic [DATA_WIDTH-1:0]          out_value1,
    output logic [DATA_WIDTH-1:0]          out_value2,
    output logic [DATA_WIDTH-1:0]          out_imm,
    output logic [DATA_WIDTH-1:0]          out_pc,
    output logic [ROB_TAG_WIDTH-1:0]       out_rob_tag
);

    logic [RS_SIZE-1:0]             busy;
    logic [INSIDE_OPCODE_WIDTH-1:0] op_q    [RS_SIZE];
    operand_t                       opnd1_q [RS_SIZE];
    operand_t                       opnd2_q [RS_SIZE];
    logic [DATA_WIDTH-1:0]          imm_q   [RS_SIZE];
    logic [DATA_WIDTH-1:0]          pc_q    [RS_SIZE];
    logic [ROB_TAG_WIDTH-1:0]       rob_q   [RS_SIZE];
    logic [RS_IDX_W:0]              count;

    logic [RS_SIZE-1:0]  ready_vec;
    logic [RS_IDX_W-1:0] free_idx;
    logic [RS_IDX_W-1:0] ready_idx;
    logic                free_found;
    logic                ready_found;
    logic                accept;
    logic                issue;
    operand_t            disp1;
    operand_t            disp2;
    operand_t            wake1 [RS_SIZE];
    operand_t            wake2 [RS_SIZE];

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy[i] && (opnd1_q[i].tag == ZERO_TAG_ROB)
                                   && (opnd2_q[i].tag == ZERO_TAG_ROB);
        end
    end

    rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
        .req   (~busy),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_enc (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    assign out_full = (count == (RS_IDX_W + 1)'(RS_SIZE));
    assign accept   = in_valid && !out_full && free_found;
    assign issue    = ready_found;

    // Dispatch bypass and wakeup share the same capture rule, so a tag seen on a bus is never missed.
    always_comb begin
        disp1 = capture('{value: in_value1, tag: in_tag1},
                        cdb_alu_tag, cdb_alu_value, cdb_lsb_tag, cdb_lsb_value);
        disp2 = capture('{value: in_value2, tag: in_tag2},
                        cdb_alu_tag, cdb_alu_value, cdb_lsb_tag, cdb_lsb_value);
        for (int i = 0; i < RS_SIZE; i++) begin
            wake1[i] = capture(opnd1_q[i], cdb_alu_tag, cdb_alu_value, cdb_lsb_tag, cdb_lsb_value);
            wake2[i] = capture(opnd2_q[i], cdb_alu_tag, cdb_alu_value, cdb_lsb_tag, cdb_lsb_value);
        end
    end

    // Control state and the registered issue port; the freed and the written entry never coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= '0;
            count       <= '0;
            out_op      <= NOP;
            out_value1  <= '0;
            out_value2  <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            out_rob_tag <= ZERO_TAG_ROB;
        end else if (rdy) begin
            if (clear) begin
                busy        <= '0;
                count       <= '0;
                out_op      <= NOP;
                out_value1  <= '0;
                out_value2  <= '0;
                out_imm     <= '0;
                out_pc      <= '0;
                out_rob_tag <= ZERO_TAG_ROB;
            end else begin
                if (issue) begin
                    busy[ready_idx] <= 1'b0;
                    out_op          <= op_q[ready_idx];
                    out_value1      <= opnd1_q[ready_idx].value;
                    out_value2      <= opnd2_q[ready_idx].value;
                    out_imm         <= imm_q[ready_idx];
                    out_pc          <= pc_q[ready_idx];
                    out_rob_tag     <= rob_q[ready_idx];
                end else begin
                    out_op      <= NOP;
                    out_value1  <= '0;
                    out_value2  <= '0;
                    out_imm     <= '0;
                    out_pc      <= '0;
                    out_rob_tag <= ZERO_TAG_ROB;
                end
                if (accept) begin
                    busy[free_idx] <= 1'b1;
                end
                count <= count + (RS_IDX_W + 1)'(accept) - (RS_IDX_W + 1)'(issue);
            end
        end
    end

    // NOTE: the payload arrays are deliberately not reset; busy alone decides whether an entry is live.
    always_ff @(posedge clk) begin
        if (rdy && !clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                opnd1_q[i] <= wake1[i];
                opnd2_q[i] <= wake2[i];
            end
            if (accept) begin
                op_q[free_idx]    <= in_op;
                opnd1_q[free_idx] <= disp1;
                opnd2_q[free_idx] <= disp2;
                imm_q[free_idx]   <= in_imm;
                pc_q[free_idx]    <= in_pc;
                rob_q[free_idx]   <= in_rob_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed scenarios plus a random phase,
// all compared every cycle against a slot-level behavioural model of the station.
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    localparam int OW = INSIDE_OPCODE_WIDTH;
    localparam int TW = ROB_TAG_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rdy, clear, in_valid;
    logic [OW-1:0] in_op;
    logic [DW-1:0] in_value1, in_value2, in_imm, in_pc;
    logic [TW-1:0] in_tag1, in_tag2, in_rob_tag;
    logic [TW-1:0] cdb_alu_tag, cdb_lsb_tag;
    logic [DW-1:0] cdb_alu_value, cdb_lsb_value;
    logic          out_full;
    logic [OW-1:0] out_op;
    logic [DW-1:0] out_value1, out_value2, out_imm, out_pc;
    logic [TW-1:0] out_rob_tag;

    int errors = 0;
    int checks = 0;

    // Behavioural model: one record per slot, occupancy derived by counting live slots.
    bit            m_busy [RS_SIZE];
    logic [OW-1:0] m_op   [RS_SIZE];
    logic [DW-1:0] m_v1 [RS_SIZE], m_v2 [RS_SIZE], m_imm [RS_SIZE], m_pc [RS_SIZE];
    logic [TW-1:0] m_q1 [RS_SIZE], m_q2 [RS_SIZE], m_rob [RS_SIZE];
    logic [OW-1:0] e_op;
    logic [DW-1:0] e_v1, e_v2, e_imm, e_pc;
    logic [TW-1:0] e_rob;

    alu_rs_scheduler #(.RS_SIZE(RS_SIZE), .RS_IDX_W(RS_IDX_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .in_valid(in_valid), .in_op(in_op),
        .in_value1(in_value1), .in_value2(in_value2),
        .in_tag1(in_tag1), .in_tag2(in_tag2),
        .in_imm(in_imm), .in_pc(in_pc), .in_rob_tag(in_rob_tag),
        .out_full(out_full),
        .cdb_alu_tag(cdb_alu_tag), .cdb_alu_value(cdb_alu_value),
        .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_value(cdb_lsb_value),
        .out_op(out_op), .out_value1(out_value1), .out_value2(out_value2),
        .out_imm(out_imm), .out_pc(out_pc), .out_rob_tag(out_rob_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int occupancy();
        int n = 0;
        for (int i = 0; i < RS_SIZE; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 1'b0;
        e_op = NOP; e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_rob = '0;
    endtask

    // Value a source takes given the broadcasts visible this cycle (ALU bus wins).
    task automatic resolve(input logic [TW-1:0] q, input logic [DW-1:0] v,
                           output logic [TW-1:0] q_out, output logic [DW-1:0] v_out);
        q_out = q; v_out = v;
        if (q != 0 && q == cdb_alu_tag) begin
            q_out = 0; v_out = cdb_alu_value;
        end else if (q != 0 && q == cdb_lsb_tag) begin
            q_out = 0; v_out = cdb_lsb_value;
        end
    endtask

    task automatic model_edge();
        int  f = -1;
        int  r = -1;
        bit  full;
        if (!rdy) return;
        if (clear) begin
            model_reset();
            return;
        end
        full = (occupancy() == RS_SIZE);
        for (int i = 0; i < RS_SIZE; i++) begin
            if (f < 0 && !m_busy[i]) f = i;
            if (r < 0 && m_busy[i] && m_q1[i] == 0 && m_q2[i] == 0) r = i;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (m_busy[i]) begin
                resolve(m_q1[i], m_v1[i], m_q1[i], m_v1[i]);
                resolve(m_q2[i], m_v2[i], m_q2[i], m_v2[i]);
            end
        end
        if (r >= 0) begin
            e_op = m_op[r]; e_v1 = m_v1[r]; e_v2 = m_v2[r];
            e_imm = m_imm[r]; e_pc = m_pc[r]; e_rob = m_rob[r];
            m_busy[r] = 1'b0;
        end else begin
            e_op = NOP; e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_rob = '0;
        end
        if (in_valid && !full && f >= 0) begin
            m_busy[f] = 1'b1;
            m_op[f] = in_op; m_imm[f] = in_imm; m_pc[f] = in_pc; m_rob[f] = in_rob_tag;
            resolve(in_tag1, in_value1, m_q1[f], m_v1[f]);
            resolve(in_tag2, in_value2, m_q2[f], m_v2[f]);
        end
    endtask

    task automatic compare_all(input string name);
        check({name, "/op"}, 160'(out_op), 160'(e_op));
        check({name, "/data"}, 160'({out_value1, out_value2, out_imm, out_pc, out_rob_tag}),
              160'({e_v1, e_v2, e_imm, e_pc, e_rob}));
        check({name, "/full"}, 160'(out_full), 160'(occupancy() == RS_SIZE));
    endtask

    task automatic tick(input string name);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(name);
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; clear = 1'b0; in_valid = 1'b0; in_op = NOP;
        in_value1 = '0; in_value2 = '0; in_tag1 = '0; in_tag2 = '0;
        in_imm = '0; in_pc = '0; in_rob_tag = '0;
        cdb_alu_tag = '0; cdb_alu_value = '0; cdb_lsb_tag = '0; cdb_lsb_value = '0;
    endtask

    task automatic set_dispatch(input logic [OW-1:0] op, input logic [DW-1:0] v1,
                                input logic [TW-1:0] t1, input logic [DW-1:0] v2,
                                input logic [TW-1:0] t2, input logic [DW-1:0] imm,
                                input logic [TW-1:0] rob);
        in_valid = 1'b1; in_op = op; in_value1 = v1; in_tag1 = t1;
        in_value2 = v2; in_tag2 = t2; in_imm = imm; in_pc = 32'h1000 + 32'(rob) * 4;
        in_rob_tag = rob;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #12;
        compare_all("reset");
        rst = 1'b1;
        tick("idle");

        // Ready-at-dispatch ADDI issues one cycle after the dispatch edge.
        set_dispatch(ADDI, 32'd5, 0, 32'd0, 0, 32'd3, 5'd9);
        tick("addi_disp");
        idle_inputs();
        tick("addi_issue");
        check("addi_op", 160'(out_op), 160'(ADDI));
        check("addi_v1_imm_rob", 160'({out_value1, out_imm, out_rob_tag}), 160'({32'd5, 32'd3, 5'd9}));
        tick("addi_after");
        check("addi_nop", 160'(out_op), 160'(NOP));

        // Wakeup from the LSB bus two cycles after dispatch.
        set_dispatch(ADD, 32'd0, 5'd3, 32'd7, 0, 32'd0, 5'd10);
        tick("add_disp");
        idle_inputs();
        tick("add_wait");
        cdb_lsb_tag = 5'd3; cdb_lsb_value = 32'h1234;
        tick("add_wake");
        idle_inputs();
        tick("add_issue");
        check("wake_v1", 160'({out_op, out_value1}), 160'({ADD, 32'h1234}));

        // Same-cycle bypass from the ALU bus.
        set_dispatch(SUB, 32'd0, 5'd4, 32'd0, 5'd4, 32'd0, 5'd11);
        cdb_alu_tag = 5'd4; cdb_alu_value = 32'hBEEF;
        tick("byp_disp");
        idle_inputs();
        tick("byp_issue");
        check("bypass", 160'({out_op, out_value1, out_value2}), 160'({SUB, 32'hBEEF, 32'hBEEF}));

        // Fill all slots waiting on tag 7; the extra dispatch is dropped.
        for (int i = 0; i < RS_SIZE; i++) begin
            set_dispatch(ADD, 32'd0, 5'd7, 32'(i), 0, 32'(i), TW'(i + 1));
            tick("fill");
        end
        check("full_set", 160'(out_full), 160'(1));
        set_dispatch(JAL, 32'd0, 0, 32'd0, 0, 32'd0, 5'd20);
        tick("drop");
        idle_inputs();
        cdb_alu_tag = 5'd7; cdb_alu_value = 32'd100;
        tick("fill_wake");
        idle_inputs();
        for (int i = 0; i < RS_SIZE; i++) begin
            tick("drain");
            check("drain_order", 160'({out_op, out_rob_tag, out_value1}), 160'({ADD, TW'(i + 1), 32'd100}));
            if (i == 0) check("full_fall", 160'(out_full), 160'(0));
        end
        tick("drain_done");
        check("drain_nop", 160'(out_op), 160'(NOP));

        // Clear overrides a simultaneous dispatch and wakeup.
        for (int i = 0; i < 4; i++) begin
            set_dispatch(SLT, 32'd0, 5'd6, 32'd1, 0, 32'd0, TW'(21 + i));
            tick("clr_fill");
        end
        set_dispatch(ADD, 32'd1, 0, 32'd2, 0, 32'd0, 5'd25);
        cdb_alu_tag = 5'd6; cdb_alu_value = 32'd55; clear = 1'b1;
        tick("clear");
        check("clear_nop", 160'({out_op, out_full}), 160'({NOP, 1'b0}));
        idle_inputs();
        cdb_alu_tag = 5'd6; cdb_alu_value = 32'd55;
        for (int i = 0; i < 3; i++) tick("clr_after");

        // Freeze with rdy low: outputs hold, dispatch and clear ignored.
        idle_inputs();
        set_dispatch(ADD, 32'd1, 0, 32'd2, 0, 32'd0, 5'd11);
        tick("frz_a");
        set_dispatch(SUB, 32'd9, 0, 32'd3, 0, 32'd0, 5'd12);
        tick("frz_b");
        idle_inputs();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                set_dispatch(JAL, 32'd0, 0, 32'd0, 0, 32'd0, 5'd30);
                clear = 1'b1;
            end else begin
                in_valid = 1'b0; clear = 1'b0;
            end
            tick("frozen");
            check("frz_hold", 160'({out_op, out_rob_tag}), 160'({ADD, 5'd11}));
        end
        idle_inputs();
        tick("thaw");
        check("thaw_issue", 160'({out_op, out_rob_tag}), 160'({SUB, 5'd12}));
        tick("thaw_idle");

        // Asynchronous reset between edges discards everything.
        set_dispatch(ADDI, 32'd8, 0, 32'd0, 0, 32'd1, 5'd13);
        tick("ar_disp1");
        set_dispatch(ADD, 32'd0, 5'd5, 32'd0, 0, 32'd0, 5'd14);
        tick("ar_disp2");
        idle_inputs();
        check("ar_before", 160'(out_op), 160'(ADDI));
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #1 rst = 1'b1;
        cdb_alu_tag = 5'd5; cdb_alu_value = 32'd77;
        tick("ar_wake");
        idle_inputs();
        for (int i = 0; i < 3; i++) tick("ar_after");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            rdy   = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) != 0) begin
                set_dispatch(OW'($urandom_range(1, 6)), $urandom, TW'($urandom_range(0, 7)),
                             $urandom, TW'($urandom_range(0, 7)), $urandom, TW'($urandom_range(1, 31)));
            end
            cdb_alu_tag = TW'($urandom_range(0, 7)); cdb_alu_value = $urandom;
            cdb_lsb_tag = TW'($urandom_range(0, 7)); cdb_lsb_value = $urandom;
            if (cdb_lsb_tag == cdb_alu_tag) cdb_lsb_tag = '0;
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
